// File: rtl/uart_tx.sv
// uart_tx: FIFO-buffered serial transmitter that sends LSB first and moves one bit per baud tick.
// Define UART_TX_PARITY_EN to send an even-parity bit after the MSB.
module uart_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        tick,
    input  logic [DATA_BITS-1:0]        in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic                        tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned BitW = $clog2(DATA_BITS + 1);
    localparam logic [CntW-1:0] Full     = CntW'(FIFO_DEPTH);
    localparam logic [BitW-1:0] LastBit  = BitW'(DATA_BITS);
    localparam logic            StopLast = (STOP_BITS == 2);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

    // ---------------- input FIFO ----------------
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PtrW-1:0]      wptr_q, rptr_q;
    logic [CntW-1:0]      count_q;
    logic                 push, pop;
    logic [DATA_BITS-1:0] head;
    logic                 fifo_has;

    assign in_ready   = (count_q != Full);
    assign push       = in_valid && in_ready;
    assign fifo_count = count_q;
    assign head       = mem[rptr_q];
    assign fifo_has   = (count_q != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + PtrW'(1);
            if (pop)  rptr_q <= rptr_q + PtrW'(1);
            if (push && !pop) begin
                count_q <= count_q + CntW'(1);
            end else if (!push && pop) begin
                count_q <= count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !rst) mem[wptr_q] <= in_data;
    end

    // ---------------- transmit FSM ----------------
    state_e               state_q, state_d;
    logic                 tx_q, tx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
    logic                 stop_cnt_q, stop_cnt_d;
    logic                 load;
`ifdef UART_TX_PARITY_EN
    logic                 par_q, par_d;
`endif

    assign tx   = tx_q;
    assign busy = (state_q != StIdle);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            tx_q       <= 1'b1;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tx_q       <= tx_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
`ifdef UART_TX_PARITY_EN
            par_q      <= par_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        tx_d       = tx_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        load       = 1'b0;
        pop        = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d      = par_q;
`endif

        unique case (state_q)
            StIdle: begin
                tx_d = 1'b1;
                if (tick && fifo_has) load = 1'b1;
            end
            StStart: begin
                if (tick) begin
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                    bit_cnt_d = BitW'(1);
                    state_d   = StData;
                end
            end
            StData: begin
                if (tick) begin
                    if (bit_cnt_q != LastBit) begin
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
                        bit_cnt_d = bit_cnt_q + BitW'(1);
                    end else begin
`ifdef UART_TX_PARITY_EN
                        tx_d    = par_q;
                        state_d = StParity;
`else
                        tx_d       = 1'b1;
                        stop_cnt_d = 1'b0;
                        state_d    = StStop;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            StParity: begin
                if (tick) begin
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                    state_d    = StStop;
                end
            end
`endif
            StStop: begin
                if (tick) begin
                    if (stop_cnt_q != StopLast) begin
                        stop_cnt_d = stop_cnt_q + 1'b1;
                    end else if (fifo_has) begin
                        // Final stop tick doubles as the next start bit: no idle gap.
                        load = 1'b1;
                    end else begin
                        tx_d    = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = StIdle;
            end
        endcase

        if (load) begin
            pop       = 1'b1;
            shift_d   = head;
            tx_d      = 1'b0;
            bit_cnt_d = '0;
            state_d   = StStart;
`ifdef UART_TX_PARITY_EN
            par_d     = ^head;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: hand-written frame vectors plus random traffic against a frame-level line model.
module tb_uart_tx;
    localparam int DataBits  = 8;
    localparam int Depth     = 4;
    localparam int StopBits  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int Par = 1;
`else
    localparam int Par = 0;
`endif
    localparam int FrameLen  = 1 + DataBits + Par + StopBits;
    localparam int BitPeriod = 16;

    logic       clk = 1'b0;
    logic       rst, tick, in_valid, in_ready, tx, busy;
    logic [7:0] in_data;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    uart_tx #(
        .DATA_BITS  (DataBits),
        .FIFO_DEPTH (Depth),
        .STOP_BITS  (StopBits)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tick       (tick),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    int checks   = 0;
    int failures = 0;

    // Line model: queued bytes, and the bits of the frame still to be put on the line.
    logic [7:0] mq[$];
    bit         mbits[$];
    logic       m_tx   = 1'b1;
    logic       m_busy = 1'b0;

    typedef struct {
        logic [7:0]  data;
        logic [0:10] line;   // time order: start, d0..d7, parity, stop
    } vec_t;
    vec_t vecs[8];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    task automatic step(input logic t, input logic v, input logic [7:0] d, input logic r);
        logic       m_ready;
        logic [7:0] b;
        tick = t; in_valid = v; in_data = d; rst = r;
        m_ready = (mq.size() != Depth);
        if (r) begin
            mq.delete();
            mbits.delete();
            m_tx   = 1'b1;
            m_busy = 1'b0;
        end else begin
            if (t) begin
                if (mbits.size() != 0) begin
                    m_tx = mbits.pop_front();
                end else if (mq.size() != 0) begin
                    b = mq.pop_front();
                    mbits.push_back(1'b0);
                    for (int i = 0; i < DataBits; i++) mbits.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
                    mbits.push_back(^b);
`endif
                    for (int i = 0; i < StopBits; i++) mbits.push_back(1'b1);
                    m_tx   = mbits.pop_front();
                    m_busy = 1'b1;
                end else begin
                    m_tx   = 1'b1;
                    m_busy = 1'b0;
                end
            end
            if (v && m_ready) mq.push_back(d);
        end
        @(posedge clk);
        #1;
        chk("tx", tx, m_tx);
        chk("busy", busy, m_busy);
        chk("fifo_count", fifo_count, mq.size());
        chk("in_ready", in_ready, (mq.size() != Depth) ? 1 : 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic push(input logic [7:0] d);
        step(1'b0, 1'b1, d, 1'b0);
    endtask

    // One tick, sample the bit it drove, then hold for the rest of the bit period.
    task automatic tick_bit(output logic s);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        s = tx;
        idle(BitPeriod - 1);
    endtask

    task automatic recv_rest(output logic [7:0] b);
        logic s;
        b = 8'h00;
        for (int i = 0; i < DataBits; i++) begin
            tick_bit(s);
            b[i] = s;
        end
`ifdef UART_TX_PARITY_EN
        tick_bit(s);
        chk("parity_bit", s, ^b);
`endif
        for (int i = 0; i < StopBits; i++) begin
            tick_bit(s);
            chk("stop_bit", s, 1);
        end
    endtask

    task automatic recv_frame(output logic [7:0] b);
        logic s;
        tick_bit(s);
        chk("start_bit", s, 0);
        recv_rest(b);
    endtask

    initial begin
        logic [7:0] got;
        logic       s;
        int         bcnt;

        vecs[0] = '{8'hA5, 11'b0_10100101_0_1};
        vecs[1] = '{8'h00, 11'b0_00000000_0_1};
        vecs[2] = '{8'hFF, 11'b0_11111111_0_1};
        vecs[3] = '{8'h07, 11'b0_11100000_1_1};
        vecs[4] = '{8'h03, 11'b0_11000000_0_1};
        vecs[5] = '{8'h3C, 11'b0_00111100_0_1};
        vecs[6] = '{8'h80, 11'b0_00000001_1_1};
        vecs[7] = '{8'h5A, 11'b0_01011010_0_1};

        // Reset values
        step(1'b0, 1'b0, 8'h00, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("rst_tx", tx, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", in_ready, 1);
        idle(2);

        // Tick with empty FIFO does nothing; tick in the push cycle does not start the frame
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("empty_tick_busy", busy, 0);
        step(1'b1, 1'b1, 8'h5A, 1'b0);
        chk("push_tick_busy", busy, 0);
        chk("push_tick_tx", tx, 1);
        chk("push_tick_count", fifo_count, 1);
        idle(3);
        tick_bit(s);
        chk("first_start", s, 0);
        recv_rest(got);
        chk("first_byte", got, 8'h5A);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("first_end_busy", busy, 0);
        idle(4);

        // Table-driven single frames, tick every 16 cycles
        foreach (vecs[r]) begin
            push(vecs[r].data);
            idle(3);
            bcnt = 0;
            for (int p = 0; p < 11; p++) begin
`ifndef UART_TX_PARITY_EN
                if (p == 9) continue;
`endif
                step(1'b1, 1'b0, 8'h00, 1'b0);
                chk("vec_bit", tx, vecs[r].line[p]);
                if (busy) bcnt++;
                for (int k = 1; k < BitPeriod; k++) begin
                    step(1'b0, 1'b0, 8'h00, 1'b0);
                    if (busy) bcnt++;
                end
            end
            step(1'b1, 1'b0, 8'h00, 1'b0);
            chk("vec_busy_len", bcnt, BitPeriod * FrameLen);
            chk("vec_idle_tx", tx, 1);
            chk("vec_idle_busy", busy, 0);
            idle(5);
        end

        // Back-to-back: no idle bit between frames
        push(8'h00);
        push(8'hFF);
        idle(2);
        recv_frame(got);
        chk("b2b_first", got, 8'h00);
        tick_bit(s);
        chk("b2b_start", s, 0);
        chk("b2b_busy", busy, 1);
        recv_rest(got);
        chk("b2b_second", got, 8'hFF);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("b2b_end_busy", busy, 0);
        idle(4);

        // Full FIFO: fifth push dropped
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        chk("full_ready", in_ready, 0);
        chk("full_count", fifo_count, 4);
        push(8'h55);
        chk("full_drop_count", fifo_count, 4);
        for (int i = 0; i < 4; i++) begin
            recv_frame(got);
            chk("full_order", got, 8'h11 * (i + 1));
        end
        step(1'b1, 1'b0, 8'h00, 1'b0);
        tick_bit(s);
        chk("full_no_fifth_tx", s, 1);
        chk("full_no_fifth_busy", busy, 0);
        idle(4);

        // Simultaneous push and pop
        push(8'hA1);
        push(8'hB2);
        step(1'b1, 1'b1, 8'hC3, 1'b0);
        chk("sim_count", fifo_count, 2);
        chk("sim_start", tx, 0);
        idle(BitPeriod - 1);
        recv_rest(got);
        chk("sim_a", got, 8'hA1);
        recv_frame(got);
        chk("sim_b", got, 8'hB2);
        recv_frame(got);
        chk("sim_c", got, 8'hC3);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        chk("sim_end_busy", busy, 0);
        chk("sim_end_count", fifo_count, 0);
        idle(4);

        // Reset during data bit 3 of 0x3C, with two more bytes queued; also a tick and push
        push(8'h3C);
        push(8'h11);
        push(8'h22);
        for (int i = 0; i < 4; i++) tick_bit(s);
        step(1'b1, 1'b0, 8'h00, 1'b0);
        idle(5);
        step(1'b1, 1'b1, 8'h99, 1'b1);
        chk("rstmid_tx", tx, 1);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_count", fifo_count, 0);
        for (int i = 0; i < 12; i++) begin
            tick_bit(s);
            chk("rstmid_quiet_tx", s, 1);
            chk("rstmid_quiet_busy", busy, 0);
        end

        // Random traffic against the model
        for (int i = 0; i < 5000; i++) begin
            step(($urandom_range(0, 5) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 8'($urandom),
                 ($urandom_range(0, 1999) == 0) ? 1'b1 : 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmit stage that sits directly downstream of the baud-rate generator. It buffers parallel bytes from the host in a small FIFO and shifts each one out on `tx` as an 8N1 frame (optionally with parity). It advances exactly one bit per single-cycle baud `tick` pulse from the generator, so every bit on the line lasts exactly one tick period.

## Interface
Parameters:
- `DATA_BITS`, 8, data bits per frame, LSB first; legal values 5..8.
- `FIFO_DEPTH`, 4, input FIFO entries; power of two, 2..16.
- `STOP_BITS`, 1, stop bits per frame; legal values 1 or 2.

Ports:
- `clk`  in  1  system clock (50 MHz); every register updates on `posedge clk`.
- `rst`  in  1  synchronous reset, active-high.
- `tick`  in  1  baud pulse from the baud generator; high for one `clk` cycle per bit period.
- `in_data`  in  DATA_BITS  byte to transmit.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  FIFO can accept a byte; equals `fifo_count != FIFO_DEPTH`.
- `tx`  out  1  serial line; idles high; registered.
- `busy`  out  1  high whenever the state is not IDLE.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  number of occupied FIFO entries.

## Operation
- Push: a byte is written when `in_valid && in_ready`. It is not accepted when the FIFO is full.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- IDLE:
  - `tx`=1.
  - If `tick` and `fifo_count>0`: pop the head into the shift register, set `tx`=0, clear the bit counter, go to START.
  - A tick with an empty FIFO does nothing.
- START:
  - On `tick`: set `tx`=shift[0], shift right, bit counter=1, go to DATA.
- DATA:
  - On `tick`, if bit counter < DATA_BITS: drive the next bit and increment the counter.
  - Else: go to PARITY (if enabled) and drive the parity bit, or go to STOP and drive `tx`=1.
- PARITY:
  - On `tick`: go to STOP, `tx`=1.
- STOP:
  - Holds for STOP_BITS tick periods.
  - On the final stop tick, if the FIFO is non-empty, pop immediately and drive `tx`=0 (back-to-back START, no idle gap).
  - Otherwise go to IDLE with `tx`=1.
- Between ticks, the state and `tx` are held.
- Simultaneous push and pop in the same cycle: both take effect and `fifo_count` is unchanged. A push while the FIFO is full is ignored, and `in_ready` is already low.
- FIFO pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_count`=0, `in_ready`=1, state IDLE, pointers 0.
- Reset mid-frame: `tx`=1 on the next cycle, the FIFO is flushed, and no partial frame resumes.
- Reset has priority over `tick` and over a push in the same cycle.
- Latency from push to start bit: the first `tick` at least one cycle after the push, when idle with an empty FIFO.
- A tick in the same cycle as the push does not start the frame.
- `tx` changes only in the cycle after a `tick`, because it is registered.
- Frame length in ticks: 1 + DATA_BITS + parity (0 or 1) + STOP_BITS.
- `busy` rises in the cycle the start bit is driven. It falls in the cycle `tx` returns to idle after the last stop bit.

## Configuration
- `UART_TX_PARITY_EN`:
  - Defined: adds the PARITY state. The parity bit is even parity, i.e. the XOR of all data bits, and is sent after the MSB.
  - Undefined: no PARITY state; STOP follows DATA directly.

## Test plan
- Single byte: push 0xA5 with `tick` every 16 cycles. Required: `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles; `busy` high for 160 cycles.
- Back-to-back: push 0x00 then 0xFF. Required: the 0x00 stop bit is followed immediately by the 0xFF start bit with no idle bit.
- Full FIFO: push 5 bytes with no ticks. Required: `in_ready`=0 after the 4th push, the 5th push is dropped, and `fifo_count`=4. Then run ticks and confirm exactly 4 frames in order.
- Simultaneous push and pop: FIFO holds 2 entries; push in the same cycle as a pop-triggering tick. Required: `fifo_count` stays 2 and data order is preserved.
- Reset mid-frame: assert `rst` during DATA bit 3 of 0x3C with 2 more bytes queued. Required: next cycle `tx`=1, `busy`=0, `fifo_count`=0; no further frames are sent.
- Parity (macro defined): send 0x07. Required: parity bit=1 and the frame is 11 ticks long. Send 0x03: parity bit=0.
